ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 Parameters: none; bus address width fixed at 7 bits, data width at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid&cmd_ready.
REQ-006 cmd_write  input  1  1=write burst, 0=read burst.
REQ-007 cmd_addr  input  7  start byte address.
REQ-008 cmd_size  input  2  0=byte, 1=halfword, 2=word; 3 treated as 2.
REQ-009 cmd_beats  input  5  beat count 1..16; 0 treated as 1, values >16 clamped to 16.
REQ-010 wr_data  input  32  write beat data.
REQ-011 wr_valid  input  1  write beat available.
REQ-012 wr_ready  output  1  pops wr_data in the cycle its write address phase completes.
REQ-013 rd_data  output  32  registered read beat data.
REQ-014 rd_valid  output  1  one-cycle pulse per read beat returned with OKAY.
REQ-015 done  output  1  one-cycle pulse when a command finishes, normally or aborted.
REQ-016 err  output  1  valid with done; 1 = command terminated by ERROR response.
REQ-017 hsel  output  1  high while htrans is NONSEQ, SEQ or BUSY.
REQ-018 haddr  output  7  address-phase address.
REQ-019 htrans  output  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-020 hsize  output  2  transfer size for the current command.
REQ-021 hwrite  output  1  copy of cmd_write for the current command.
REQ-022 hburst  output  3  SINGLE (000) when beats==1, INCR (001) otherwise.
REQ-023 hwdata  output  32  data-phase write data, registered.
REQ-024 hrdata  input  32  slave read data.
REQ-025 hready  input  1  slave ready; a phase completes on a clk edge with hready=1.
REQ-026 hresp  input  1  0=OKAY, 1=ERROR (two-cycle response).

Function
REQ-027 FSM states: IDLE, ADDR (address phase only), PIPE (address n+1 overlapped with data n), LAST (final data phase only), ERR.
REQ-028 IDLE: on command accept, latch all cmd fields; next cycle ADDR with htrans=NONSEQ, haddr=cmd_addr.
REQ-029 Address phases hold haddr/htrans/hsize/hwrite/hburst stable until completed by hready=1.
REQ-030 Each completed address phase increments the address by 1<<size, modulo 128 (wrap, no error), and decrements the remaining-beat counter.
REQ-031 Later beats use htrans=SEQ; after the last address phase completes, htrans=IDLE and the FSM enters LAST.
REQ-032 Writes: if wr_valid=0 when a beat's address phase is due, drive htrans=IDLE (first beat) or BUSY (later beats) and advance nothing until wr_valid=1.
REQ-033 Writes: hwdata is loaded from wr_data on completion of that beat's address phase and held through its data phase, so hwdata is never changed while hready=0.
REQ-034 Reads: on a data phase completing with hresp=0, rd_data<=hrdata and rd_valid=1 the next cycle; no read backpressure.
REQ-035 Error: on hresp=1 with hready=0, the next cycle drives htrans=IDLE (any pending address phase cancelled) and enters ERR; remaining beats are dropped, no rd_valid, no wr_ready.
REQ-036 ERR waits for hready=1 (second response cycle), then pulses done with err=1 and returns to IDLE.
REQ-037 Normal completion: the final data phase completes with OKAY -> done=1, err=0 the next cycle; return to IDLE; cmd_ready high the cycle after done.
REQ-038 Single-beat command: ADDR -> LAST -> IDLE; minimum latency accept-to-done = 3 cycles with zero wait states.
REQ-039 A 16-beat zero-wait burst issues 16 consecutive address phases with no IDLE gaps.

Reset
REQ-040 n_rst low asynchronously forces IDLE; htrans=0, hsel=0, haddr=0, hsize=0, hwrite=0, hburst=0, hwdata=0, rd_data=0, rd_valid=0, done=0, err=0, wr_ready=0, internal counters=0, cmd_ready=1 after release.
REQ-041 Reset mid-burst abandons the burst; no done pulse is produced for it.

Verification
REQ-042 Read, addr=0x00, size=2, beats=4, zero-wait, hrdata=0x11,0x22,0x33,0x44 -> haddr 0,4,8,12; htrans NONSEQ,SEQ,SEQ,SEQ; hburst=001; 4 rd_valid pulses carrying those values; done, err=0.
REQ-043 Write, addr=0x48, size=0, beats=1, wr_data=0x05 -> hburst=000, htrans=NONSEQ one cycle, hwdata=0x05 in data phase; done, err=0.
REQ-044 Read, beats=3, hready low 2 cycles on beat 2 -> haddr/hrdata sampling held, 3 rd_valid, done 2 cycles later than zero-wait.
REQ-045 Write, beats=4, wr_valid low before beat 3 for 3 cycles -> htrans=BUSY 3 cycles, haddr unchanged, then SEQ resumes; 4 wr_ready pulses.
REQ-046 Write to 0x40 with slave ERROR on beat 1 of 4 -> htrans=IDLE next cycle, no further beats, done=1 err=1.
REQ-047 Read from 0x7C, size=2, beats=2 -> second address wraps to 0x00; n_rst pulsed mid-burst -> all outputs at reset values, no done.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite burst master: turns one command (read/write, start address, size,
// 1..16 beats) into a pipelined SINGLE/INCR burst, with write-data stalls and ERROR abort.
module ahb_lite_master (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [4:0]  cmd_beats,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic        hsel,
  output logic [6:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_PIPE, ST_LAST, ST_ERR} state_t;

  state_t      state_q, state_d;
  logic [4:0]  beats_q, beats_d;
  logic        first_q, first_d;
  logic [6:0]  addr_d;
  logic [1:0]  size_d;
  logic        write_d;
  logic [2:0]  burst_d;
  logic [31:0] wdata_d, rdata_d;
  logic        rvalid_d, done_d, err_d;
  logic        addr_phase, beat_go, addr_done, data_ok;
  logic [4:0]  cmd_beats_eff;

  assign cmd_beats_eff = (cmd_beats == 5'd0) ? 5'd1 :
                         (cmd_beats > 5'd16) ? 5'd16 : cmd_beats;

  // A write beat only goes out once its data is on wr_data; wr_valid is
  // expected to stay high until wr_ready pops it, so an issued phase never retracts.
  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    first_d   = first_q;
    addr_d    = haddr;
    size_d    = hsize;
    write_d   = hwrite;
    burst_d   = hburst;
    wdata_d   = hwdata;
    rdata_d   = rd_data;
    rvalid_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    addr_phase = (state_q == ST_ADDR) || (state_q == ST_PIPE);
    beat_go    = addr_phase && (!hwrite || wr_valid);
    addr_done  = beat_go && hready;
    data_ok    = ((state_q == ST_PIPE) || (state_q == ST_LAST)) && hready && !hresp;

    htrans = TR_IDLE;
    if (addr_phase) begin
      if (beat_go) htrans = first_q ? TR_NONSEQ : TR_SEQ;
      else         htrans = first_q ? TR_IDLE : TR_BUSY;
    end
    hsel      = (htrans != TR_IDLE);
    wr_ready  = addr_done && hwrite;
    cmd_ready = (state_q == ST_IDLE) && !done;

    if (addr_done) begin
      addr_d  = haddr + (7'd1 << hsize);
      beats_d = beats_q - 5'd1;
      first_d = 1'b0;
      if (hwrite) wdata_d = wr_data;
    end
    if (data_ok && !hwrite) begin
      rdata_d  = hrdata;
      rvalid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          size_d  = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
          write_d = cmd_write;
          beats_d = cmd_beats_eff;
          burst_d = (cmd_beats_eff == 5'd1) ? 3'b000 : 3'b001;
          first_d = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (addr_done) state_d = (beats_q == 5'd1) ? ST_LAST : ST_PIPE;
      end
      ST_PIPE: begin
        if (hresp) begin
          if (hready) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (hready) begin
          if (addr_done) state_d = (beats_q == 5'd1) ? ST_LAST : ST_PIPE;
          else           state_d = ST_ADDR;
        end
      end
      ST_LAST: begin
        if (hresp && !hready) begin
          state_d = ST_ERR;
        end else if (hready) begin
          done_d  = 1'b1;
          err_d   = hresp;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (hready) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      beats_q  <= 5'd0;
      first_q  <= 1'b0;
      haddr    <= 7'd0;
      hsize    <= 2'd0;
      hwrite   <= 1'b0;
      hburst   <= 3'd0;
      hwdata   <= 32'd0;
      rd_data  <= 32'd0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      beats_q  <= beats_d;
      first_q  <= first_d;
      haddr    <= addr_d;
      hsize    <= size_d;
      hwrite   <= write_d;
      hburst   <= burst_d;
      hwdata   <= wdata_d;
      rd_data  <= rdata_d;
      rd_valid <= rvalid_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: acts as AHB slave and write-data source, records bus
// activity per command and compares it with a transaction-level model of the burst.
module tb_ahb_lite_master;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [4:0]  cmd_beats;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, err, hsel;
  logic [6:0]  haddr;
  logic [1:0]  htrans, hsize;
  logic        hwrite;
  logic [2:0]  hburst;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;

  ahb_lite_master dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_beats(cmd_beats),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Command under test and slave/source behaviour for it.
  logic        c_write;
  logic [6:0]  c_addr;
  logic [1:0]  c_size;
  logic [4:0]  c_beats;
  int          waits [16];
  int          gaps [17];
  int          err_beat;
  logic [31:0] rdat [16];
  logic [31:0] wdat [16];

  // What the bus did during the last command.
  logic [6:0]  ph_addr [$];
  logic [1:0]  ph_trans [$];
  logic [2:0]  ph_burst [$];
  logic [1:0]  ph_size [$];
  logic        ph_write [$];
  logic [31:0] rd_obs [$];
  logic [31:0] wd_obs [$];
  logic [6:0]  busy_addr [$];
  int n_pops, stab_viol, busy_cnt, stray, got_done, got_err, timeout, lat;
  int first_ph_cyc, last_ph_cyc;
  logic [1:0] after_err_trans;

  function automatic int eff_beats(input logic [4:0] b);
    if (b == 0) return 1;
    if (b > 16) return 16;
    return int'(b);
  endfunction

  function automatic int eff_size(input logic [1:0] s);
    return (s == 2'd3) ? 2 : int'(s);
  endfunction

  function automatic logic [6:0] exp_addr(input int i);
    return 7'((int'(c_addr) + i * (1 << eff_size(c_size))) % 128);
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < 16; i++) begin
      waits[i] = 0;
      rdat[i]  = $urandom;
      wdat[i]  = $urandom;
    end
    for (int i = 0; i < 17; i++) gaps[i] = 0;
    err_beat = -1;
  endtask

  task automatic run_cmd();
    int n, k, gap_left, wait_left, dp_beat, ph_cnt, acc_cyc, err_phase;
    bit accepted, dp_pending, dp_now, prev_hold, prev_dwait, new_dp;
    logic [6:0]  p_addr;
    logic [1:0]  p_trans;
    logic [31:0] p_wdata;
    n = eff_beats(c_beats);
    ph_addr.delete(); ph_trans.delete(); ph_burst.delete(); ph_size.delete(); ph_write.delete();
    rd_obs.delete(); wd_obs.delete(); busy_addr.delete();
    n_pops = 0; stab_viol = 0; busy_cnt = 0; stray = 0; got_done = 0; got_err = 0;
    timeout = 0; lat = -1; first_ph_cyc = -1; last_ph_cyc = -1; after_err_trans = 2'd3;
    k = 0; gap_left = gaps[0]; wait_left = 0; dp_beat = 0; ph_cnt = 0; acc_cyc = 0; err_phase = 0;
    accepted = 0; dp_pending = 0; prev_hold = 0; prev_dwait = 0;
    p_addr = '0; p_trans = '0; p_wdata = '0;
    for (int cyc = 0; cyc < 500 && got_done == 0; cyc++) begin
      @(negedge clk);
      cmd_valid = !accepted;
      cmd_write = c_write;
      cmd_addr  = c_addr;
      cmd_size  = c_size;
      cmd_beats = c_beats;
      wr_valid  = c_write && (k < n) && (gap_left == 0);
      wr_data   = (k < 16) ? wdat[k] : 32'h0;
      hresp  = 1'b0;
      hready = 1'b1;
      hrdata = $urandom;
      dp_now = dp_pending;
      if (err_phase == 1) begin
        hresp = 1'b1;
      end else if (dp_pending) begin
        hrdata = rdat[dp_beat];
        if (dp_beat == err_beat) begin
          hresp  = 1'b1;
          hready = 1'b0;
        end else begin
          hready = (wait_left == 0);
        end
      end
      #1;
      if (rd_valid) begin
        rd_obs.push_back(rd_data);
        if (c_write) stray++;
      end
      if (wr_ready && !c_write) stray++;
      if (done) begin
        got_done = 1;
        got_err  = int'(err);
        lat      = cyc - acc_cyc;
      end
      if (err_phase == 1) after_err_trans = htrans;
      if (prev_hold && (haddr !== p_addr || htrans !== p_trans)) stab_viol++;
      if (prev_dwait && hwdata !== p_wdata) stab_viol++;
      if (htrans == 2'd1) begin
        busy_cnt++;
        busy_addr.push_back(haddr);
      end
      if (wr_ready) begin
        n_pops++;
        k++;
        gap_left = (k < 17) ? gaps[k] : 0;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      new_dp = 0;
      if ((htrans == 2'd2 || htrans == 2'd3) && hready) begin
        ph_addr.push_back(haddr); ph_trans.push_back(htrans); ph_burst.push_back(hburst);
        ph_size.push_back(hsize); ph_write.push_back(hwrite);
        if (ph_cnt == 0) first_ph_cyc = cyc;
        last_ph_cyc = cyc;
        ph_cnt++;
        new_dp = 1;
      end
      if (err_phase == 1) begin
        err_phase = 2;
      end else if (dp_now && dp_beat == err_beat) begin
        err_phase  = 1;
        dp_pending = 0;
      end else if (dp_now && hready) begin
        if (c_write) wd_obs.push_back(hwdata);
        dp_pending = 0;
      end else if (dp_now) begin
        wait_left--;
      end
      if (new_dp) begin
        dp_pending = 1;
        dp_beat    = (ph_cnt - 1) % 16;
        wait_left  = waits[dp_beat];
      end
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
      prev_hold  = (htrans == 2'd2 || htrans == 2'd3) && !hready && !hresp;
      prev_dwait = dp_now && !hready && !hresp;
      p_addr  = haddr;
      p_trans = htrans;
      p_wdata = hwdata;
    end
    timeout   = (got_done == 0);
    wr_valid  = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #3;
    checks++;
    if ({hsel, htrans, haddr, hsize, hwrite, hburst, hwdata, rd_data, rd_valid, done, err, wr_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_in_reset: got htrans=%0h haddr=%0h hwdata=%0h rd_data=%0h done=%0b, want all 0",
               htrans, haddr, hwdata, rd_data, done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({hsel, htrans, haddr, hburst, rd_valid, done, err, wr_ready} !== '0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_after_release: got cmd_ready=%0b htrans=%0h haddr=%0h, want 1 0 0", cmd_ready, htrans, haddr);
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_d [4];
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    clear_cfg();
    c_write = 1'b0; c_addr = 7'h00; c_size = 2'd2; c_beats = 5'd4;
    for (int i = 0; i < 4; i++) rdat[i] = exp_d[i];
    run_cmd();
    checks++;
    if (got_done !== 1 || got_err !== 0) begin
      errors++;
      $display("[TB] FAIL read_burst_done: got done=%0d err=%0d, want 1 0", got_done, got_err);
    end
    checks++;
    if (ph_addr.size() != 4) begin
      errors++;
      $display("[TB] FAIL read_burst_phases: got %0d, want 4", ph_addr.size());
    end
    for (int i = 0; i < 4 && i < ph_addr.size(); i++) begin
      logic [1:0] et;
      et = (i == 0) ? 2'd2 : 2'd3;
      checks++;
      if ({ph_addr[i], ph_trans[i], ph_burst[i]} !== {exp_addr(i), et, 3'b001}) begin
        errors++;
        $display("[TB] FAIL read_burst_phase%0d: got addr=%0h trans=%0d burst=%0d, want %0h %0d 1",
                 i, ph_addr[i], ph_trans[i], ph_burst[i], exp_addr(i), et);
      end
    end
    checks++;
    if (rd_obs.size() != 4) begin
      errors++;
      $display("[TB] FAIL read_burst_rdcount: got %0d, want 4", rd_obs.size());
    end
    for (int i = 0; i < 4 && i < rd_obs.size(); i++) begin
      checks++;
      if (rd_obs[i] !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL read_burst_data%0d: got %0h, want %0h", i, rd_obs[i], exp_d[i]);
      end
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("[TB] FAIL read_burst_latency: got %0d, want 6", lat);
    end
  endtask

  task automatic test_write_single();
    clear_cfg();
    c_write = 1'b1; c_addr = 7'h48; c_size = 2'd0; c_beats = 5'd1;
    wdat[0] = 32'h05;
    run_cmd();
    checks++;
    if (got_done !== 1 || got_err !== 0 || lat != 3) begin
      errors++;
      $display("[TB] FAIL write_single_done: got done=%0d err=%0d lat=%0d, want 1 0 3", got_done, got_err, lat);
    end
    checks++;
    if (ph_addr.size() != 1 || busy_cnt != 0 || n_pops != 1) begin
      errors++;
      $display("[TB] FAIL write_single_count: got phases=%0d busy=%0d pops=%0d, want 1 0 1", ph_addr.size(), busy_cnt, n_pops);
    end else begin
      checks++;
      if ({ph_addr[0], ph_trans[0], ph_burst[0], ph_size[0], ph_write[0]} !== {7'h48, 2'd2, 3'b000, 2'd0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL write_single_phase: got addr=%0h trans=%0d burst=%0d size=%0d write=%0b, want 48 2 0 0 1",
                 ph_addr[0], ph_trans[0], ph_burst[0], ph_size[0], ph_write[0]);
      end
    end
    checks++;
    if (wd_obs.size() != 1 || wd_obs[0] !== 32'h05) begin
      errors++;
      $display("[TB] FAIL write_single_hwdata: got count=%0d first=%0h, want 1 5", wd_obs.size(), (wd_obs.size() > 0) ? wd_obs[0] : 32'hx);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_single_ready_after_done: got %0b, want 1", cmd_ready);
    end
  endtask

  task automatic test_read_wait();
    clear_cfg();
    c_write = 1'b0; c_addr = 7'h20; c_size = 2'd2; c_beats = 5'd3;
    waits[1] = 2;
    run_cmd();
    checks++;
    if (got_done !== 1 || got_err !== 0 || lat != 7) begin
      errors++;
      $display("[TB] FAIL read_wait_done: got done=%0d err=%0d lat=%0d, want 1 0 7", got_done, got_err, lat);
    end
    checks++;
    if (rd_obs.size() != 3 || stab_viol != 0) begin
      errors++;
      $display("[TB] FAIL read_wait_count: got rd=%0d unstable=%0d, want 3 0", rd_obs.size(), stab_viol);
    end
    for (int i = 0; i < 3 && i < rd_obs.size(); i++) begin
      checks++;
      if (rd_obs[i] !== rdat[i]) begin
        errors++;
        $display("[TB] FAIL read_wait_data%0d: got %0h, want %0h", i, rd_obs[i], rdat[i]);
      end
    end
  endtask

  task automatic test_write_busy();
    int bad;
    clear_cfg();
    c_write = 1'b1; c_addr = 7'h10; c_size = 2'd2; c_beats = 5'd4;
    gaps[2] = 3;
    run_cmd();
    bad = 0;
    foreach (busy_addr[i]) if (busy_addr[i] !== exp_addr(2)) bad++;
    checks++;
    if (busy_cnt != 3 || bad != 0) begin
      errors++;
      $display("[TB] FAIL write_busy_cycles: got busy=%0d wrong_addr=%0d, want 3 0", busy_cnt, bad);
    end
    checks++;
    if (n_pops != 4 || got_done !== 1 || got_err !== 0) begin
      errors++;
      $display("[TB] FAIL write_busy_pops: got pops=%0d done=%0d err=%0d, want 4 1 0", n_pops, got_done, got_err);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i >= wd_obs.size() || wd_obs[i] !== wdat[i]) bad++;
      if (i >= ph_addr.size() || ph_addr[i] !== exp_addr(i) || ph_trans[i] !== ((i == 0) ? 2'd2 : 2'd3)) bad++;
    end
    checks++;
    if (bad != 0 || stab_viol != 0) begin
      errors++;
      $display("[TB] FAIL write_busy_beats: got wrong=%0d unstable=%0d, want 0 0", bad, stab_viol);
    end
  endtask

  task automatic test_error();
    clear_cfg();
    c_write = 1'b1; c_addr = 7'h40; c_size = 2'd2; c_beats = 5'd4;
    err_beat = 0;
    run_cmd();
    checks++;
    if (got_done !== 1 || got_err !== 1) begin
      errors++;
      $display("[TB] FAIL error_done: got done=%0d err=%0d, want 1 1", got_done, got_err);
    end
    checks++;
    if (after_err_trans !== 2'd0) begin
      errors++;
      $display("[TB] FAIL error_htrans_next: got %0d, want 0", after_err_trans);
    end
    checks++;
    if (ph_addr.size() != 1 || n_pops != 1 || wd_obs.size() != 0) begin
      errors++;
      $display("[TB] FAIL error_beats: got phases=%0d pops=%0d wdata=%0d, want 1 1 0", ph_addr.size(), n_pops, wd_obs.size());
    end
  endtask

  task automatic test_long_burst();
    clear_cfg();
    c_write = 1'b0; c_addr = 7'h00; c_size = 2'd1; c_beats = 5'd16;
    run_cmd();
    checks++;
    if (ph_addr.size() != 16 || last_ph_cyc - first_ph_cyc != 15 || busy_cnt != 0) begin
      errors++;
      $display("[TB] FAIL long_burst_gapless: got phases=%0d span=%0d busy=%0d, want 16 15 0",
               ph_addr.size(), last_ph_cyc - first_ph_cyc, busy_cnt);
    end
    checks++;
    if (lat != 18 || got_err !== 0 || rd_obs.size() != 16) begin
      errors++;
      $display("[TB] FAIL long_burst_done: got lat=%0d err=%0d rd=%0d, want 18 0 16", lat, got_err, rd_obs.size());
    end
  endtask

  task automatic test_wrap_reset();
    int done_seen;
    clear_cfg();
    c_write = 1'b0; c_addr = 7'h7C; c_size = 2'd2; c_beats = 5'd2;
    run_cmd();
    checks++;
    if (ph_addr.size() != 2 || ph_addr[0] !== exp_addr(0) || ph_addr[1] !== exp_addr(1)) begin
      errors++;
      $display("[TB] FAIL wrap_addr: got count=%0d second=%0h, want 2 %0h",
               ph_addr.size(), (ph_addr.size() > 1) ? ph_addr[1] : 7'hx, exp_addr(1));
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h08; cmd_size = 2'd2; cmd_beats = 5'd8;
    hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
    repeat (4) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({hsel, htrans, haddr, hsize, hwrite, hburst, hwdata, rd_data, rd_valid, done, err, wr_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_burst: got htrans=%0h haddr=%0h rd_data=%0h rd_valid=%0b, want all 0",
               htrans, haddr, rd_data, rd_valid);
    end
    @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0 || cmd_ready !== 1'b1 || htrans !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got done_pulses=%0d cmd_ready=%0b htrans=%0d, want 0 1 0", done_seen, cmd_ready, htrans);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int n, es, exp_ph, exp_dat, bad;
      clear_cfg();
      c_write = 1'($urandom_range(0, 1));
      c_addr  = 7'($urandom);
      c_size  = 2'($urandom);
      c_beats = 5'($urandom);
      n  = eff_beats(c_beats);
      es = eff_size(c_size);
      for (int i = 0; i < 16; i++) begin
        waits[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        gaps[i]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      end
      if ($urandom_range(0, 3) == 0) err_beat = $urandom_range(0, n - 1);
      run_cmd();
      exp_ph  = (err_beat >= 0) ? err_beat + 1 : n;
      exp_dat = (err_beat >= 0) ? err_beat : n;
      checks++;
      if (timeout != 0 || got_done !== 1 || got_err !== int'(err_beat >= 0)) begin
        errors++;
        $display("[TB] FAIL rand%0d_done: got done=%0d err=%0d timeout=%0d, want 1 %0d 0",
                 t, got_done, got_err, timeout, int'(err_beat >= 0));
      end
      bad = 0;
      for (int i = 0; i < ph_addr.size() && i < exp_ph; i++) begin
        if (ph_addr[i] !== exp_addr(i)) bad++;
        if (ph_trans[i] !== ((i == 0) ? 2'd2 : 2'd3)) bad++;
        if (ph_burst[i] !== ((n == 1) ? 3'b000 : 3'b001)) bad++;
        if (ph_size[i] !== 2'(es) || ph_write[i] !== c_write) bad++;
      end
      checks++;
      if (ph_addr.size() != exp_ph || bad != 0) begin
        errors++;
        $display("[TB] FAIL rand%0d_phases: got count=%0d wrong=%0d, want %0d 0", t, ph_addr.size(), bad, exp_ph);
      end
      bad = 0;
      if (c_write) begin
        for (int i = 0; i < wd_obs.size() && i < 16; i++) if (wd_obs[i] !== wdat[i]) bad++;
        checks++;
        if (wd_obs.size() != exp_dat || n_pops != exp_ph || bad != 0) begin
          errors++;
          $display("[TB] FAIL rand%0d_wdata: got beats=%0d pops=%0d wrong=%0d, want %0d %0d 0",
                   t, wd_obs.size(), n_pops, bad, exp_dat, exp_ph);
        end
      end else begin
        for (int i = 0; i < rd_obs.size() && i < 16; i++) if (rd_obs[i] !== rdat[i]) bad++;
        checks++;
        if (rd_obs.size() != exp_dat || bad != 0) begin
          errors++;
          $display("[TB] FAIL rand%0d_rdata: got beats=%0d wrong=%0d, want %0d 0", t, rd_obs.size(), bad, exp_dat);
        end
      end
      checks++;
      if (stab_viol != 0 || stray != 0) begin
        errors++;
        $display("[TB] FAIL rand%0d_protocol: got unstable=%0d stray=%0d, want 0 0", t, stab_viol, stray);
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_beats = '0;
    wr_data = '0; wr_valid = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    test_reset();
    test_read_burst();
    test_write_single();
    test_read_wait();
    test_write_busy();
    test_error();
    test_long_burst();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
